tv80_bus_seq: RTL and testbench

Parametrised Z80-style bus-cycle sequencer. It takes per-cycle requests from the CPU core (fetch, memory read/write, I/O read/write, interrupt acknowledge) and generates the T1/T2/Tw/T3/T4 timing and the registered active-low strobes on the external bus. It extends the fixed strobe logic with programmable automatic wait states, a selectable write-strobe phase, back-to-back requests, a refresh-address counter and a request/response handshake. It sits between the core and the pad ring, replacing the wrapper-level strobe logic.

---
 rtl/tv80_bus_pkg.sv | 46 ++++
 rtl/tv80_bus_seq_if.sv | 37 +++
 rtl/tv80_bus_wait_ctr.sv | 28 ++
 rtl/tv80_bus_seq.sv | 149 ++++++++++++++
 tb/tb_tv80_bus_seq.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tv80_bus_pkg.sv
// Shared encodings for the TV80 bus-cycle sequencer: request types, FSM states
// and the wait-state counter type.
package tv80_bus_pkg;

   localparam logic [2:0] REQ_FETCH   = 3'd0;
   localparam logic [2:0] REQ_MEM_RD  = 3'd1;
   localparam logic [2:0] REQ_MEM_WR  = 3'd2;
   localparam logic [2:0] REQ_IO_RD   = 3'd3;
   localparam logic [2:0] REQ_IO_WR   = 3'd4;
   localparam logic [2:0] REQ_INT_ACK = 3'd5;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_T1   = 3'd1;
   localparam logic [2:0] ST_T2   = 3'd2;
   localparam logic [2:0] ST_TW   = 3'd3;
   localparam logic [2:0] ST_T3   = 3'd4;
   localparam logic [2:0] ST_T4   = 3'd5;

   // Programmed waits are 3 bits, but interrupt acknowledge adds one more.
   localparam int WAIT_W = 4;
   typedef logic [WAIT_W-1:0] wait_cnt_t;

   function automatic wait_cnt_t wait_load(input logic [2:0] rtype,
                                           input int mem_wait,
                                           input int io_wait);
      case (rtype)
         REQ_IO_RD, REQ_IO_WR: return wait_cnt_t'(io_wait);
         REQ_INT_ACK:          return wait_cnt_t'(io_wait + 1);
         default:              return wait_cnt_t'(mem_wait);
      endcase
   endfunction

   function automatic logic is_read(input logic [2:0] rtype);
      return (rtype == REQ_FETCH) || (rtype == REQ_MEM_RD) ||
             (rtype == REQ_IO_RD) || (rtype == REQ_INT_ACK);
   endfunction

   function automatic logic is_write(input logic [2:0] rtype);
      return (rtype == REQ_MEM_WR) || (rtype == REQ_IO_WR);
   endfunction

   function automatic logic is_reserved(input logic [2:0] rtype);
      return rtype > REQ_INT_ACK;
   endfunction

endpackage

// File: rtl/tv80_bus_seq_if.sv
// Core-side request/response handshake plus pad-side bus signals of the sequencer.
// master = core and pad ring driving requests and bus inputs; slave = sequencer.
interface tv80_bus_seq_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic [2:0]    req_type;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [AW-9:0] rfsh_page;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          wait_n;
   logic [DW-1:0] di;
   logic [AW-1:0] A;
   logic [DW-1:0] dout;
   logic          m1_n;
   logic          mreq_n;
   logic          iorq_n;
   logic          rd_n;
   logic          wr_n;
   logic          rfsh_n;

   modport master (
      output req_valid, req_type, req_addr, req_wdata, rfsh_page, wait_n, di,
      input  req_ready, rsp_valid, rsp_rdata, A, dout,
             m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
   );

   modport slave (
      input  req_valid, req_type, req_addr, req_wdata, rfsh_page, wait_n, di,
      output req_ready, rsp_valid, rsp_rdata, A, dout,
             m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
   );
endinterface

// File: rtl/tv80_bus_wait_ctr.sv
// Loadable wait-state down-counter; holds at zero and only moves on cen edges.
module tv80_bus_wait_ctr
   import tv80_bus_pkg::*;
(
   input  logic      clk,
   input  logic      reset_n,
   input  logic      cen,
   input  logic      load,
   input  wait_cnt_t load_val,
   input  logic      dec,
   output logic      zero
);
   wait_cnt_t cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (cen) begin
         if (load) begin
            cnt_reg <= load_val;
         end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
         end
      end
   end

   assign zero = (cnt_reg == '0);
endmodule

// File: rtl/tv80_bus_seq.sv
// Z80-style bus-cycle sequencer: turns core requests into T1/T2/Tw/T3/T4 timing
// with registered active-low strobes, automatic waits and DRAM refresh.
module tv80_bus_seq
   import tv80_bus_pkg::*;
#(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int T2WRITE  = 1,
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 1,
   parameter int REFRESH  = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cen,
   tv80_bus_seq_if.slave bus
);
   logic [2:0]    state_reg;
   logic [2:0]    type_reg;
   logic [7:0]    rcnt_reg;
   logic [AW-1:0] a_reg;
   logic [DW-1:0] dout_reg;
   logic [DW-1:0] rdata_reg;
   logic          m1_reg, mreq_reg, iorq_reg, rd_reg, wr_reg, rfsh_reg;
   logic          rsp_valid_reg;

   logic          fetch_rfsh;
   logic          final_st;
   logic          ready;
   logic          accept;
   logic          wait_zero;
   logic          wait_load_en;
   logic          wait_dec;
   wait_cnt_t     wait_init;

   assign fetch_rfsh   = (type_reg == REQ_FETCH) && (REFRESH != 0);
   assign final_st     = ((state_reg == ST_T3) && !fetch_rfsh) || (state_reg == ST_T4);
   assign ready        = (state_reg == ST_IDLE) || final_st;
   assign accept       = cen && bus.req_valid && ready;
   assign wait_load_en = (state_reg == ST_T1);
   assign wait_dec     = (state_reg == ST_T2) || (state_reg == ST_TW);
   assign wait_init    = wait_load(type_reg, MEM_WAIT, IO_WAIT);

   tv80_bus_wait_ctr u_wait_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .cen      (cen),
      .load     (wait_load_en),
      .load_val (wait_init),
      .dec      (wait_dec),
      .zero     (wait_zero)
   );

   always_ff @(posedge clk) begin
      // The response strobe is a one-clk pulse even when cen stretches states.
      rsp_valid_reg <= 1'b0;
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         type_reg  <= REQ_FETCH;
         rcnt_reg  <= '0;
         a_reg     <= '0;
         dout_reg  <= '0;
         rdata_reg <= '0;
         {m1_reg, mreq_reg, iorq_reg, rd_reg, wr_reg, rfsh_reg} <= '1;
      end else if (cen) begin
         case (state_reg)
            ST_T1: begin
               state_reg <= ST_T2;
               case (type_reg)
                  REQ_FETCH, REQ_MEM_RD: begin
                     mreq_reg <= 1'b0;
                     rd_reg   <= 1'b0;
                  end
                  REQ_MEM_WR: begin
                     mreq_reg <= 1'b0;
                     if (T2WRITE != 0) wr_reg <= 1'b0;
                  end
                  REQ_IO_RD: begin
                     iorq_reg <= 1'b0;
                     rd_reg   <= 1'b0;
                  end
                  REQ_IO_WR: begin
                     iorq_reg <= 1'b0;
                     wr_reg   <= 1'b0;
                  end
                  REQ_INT_ACK: iorq_reg <= 1'b0;
                  default: ;
               endcase
            end
            ST_T2, ST_TW: begin
               if (!wait_zero || !bus.wait_n) begin
                  state_reg <= ST_TW;
               end else begin
                  state_reg <= ST_T3;
                  if (is_read(type_reg)) rdata_reg <= bus.di;
                  if ((type_reg == REQ_MEM_WR) && (T2WRITE == 0)) wr_reg <= 1'b0;
                  if (fetch_rfsh) begin
                     m1_reg   <= 1'b1;
                     rd_reg   <= 1'b1;
                     mreq_reg <= 1'b1;
                     rfsh_reg <= 1'b0;
                     a_reg    <= {bus.rfsh_page, rcnt_reg};
                  end
               end
            end
            ST_T3: begin
               if (fetch_rfsh) begin
                  state_reg <= ST_T4;
                  mreq_reg  <= 1'b0;
               end
            end
            default: ;
         endcase

         if (final_st) begin
            state_reg <= ST_IDLE;
            rsp_valid_reg <= 1'b1;
            {m1_reg, mreq_reg, iorq_reg, rd_reg, wr_reg, rfsh_reg} <= '1;
            // Only the low seven bits count, as on the original Z80 R register.
            if (state_reg == ST_T4) rcnt_reg[6:0] <= rcnt_reg[6:0] + 7'd1;
         end

         // Accept last so a back-to-back request overrides the completion above.
         if (accept) begin
            if (is_reserved(bus.req_type)) begin
               rsp_valid_reg <= 1'b1;
            end else begin
               state_reg <= ST_T1;
               type_reg  <= bus.req_type;
               a_reg     <= bus.req_addr;
               if (is_write(bus.req_type)) dout_reg <= bus.req_wdata;
               m1_reg    <= !((bus.req_type == REQ_FETCH) || (bus.req_type == REQ_INT_ACK));
            end
         end
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rdata_reg;
   assign bus.A         = a_reg;
   assign bus.dout      = dout_reg;
   assign bus.m1_n      = m1_reg;
   assign bus.mreq_n    = mreq_reg;
   assign bus.iorq_n    = iorq_reg;
   assign bus.rd_n      = rd_reg;
   assign bus.wr_n      = wr_reg;
   assign bus.rfsh_n    = rfsh_reg;
endmodule

// File: tb/tb_tv80_bus_seq.sv
// Randomised bench for tv80_bus_seq: two parameterisations driven in turn and
// checked edge by edge against a phase-table model of the Z80 bus cycle.
module tb_tv80_bus_seq;
   import tv80_bus_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, cen;
   logic        req_valid;
   logic [2:0]  req_type;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata, rfsh_page, di;
   logic        wait_n;
   bit          sel;

   bit          p_t2write, p_refresh;
   int          p_mem_wait, p_io_wait;
   int          checks = 0;
   int          errors = 0;
   int          txn_no = 0;
   bit          pending;
   logic [7:0]  exp_rdata;
   logic [7:0]  rcnt_m;
   logic [5:0]  exp_now;

   tv80_bus_seq_if #(.AW(16), .DW(8)) bus0 ();
   tv80_bus_seq_if #(.AW(16), .DW(8)) bus1 ();

   tv80_bus_seq #(.AW(16), .DW(8), .T2WRITE(1), .MEM_WAIT(0), .IO_WAIT(1), .REFRESH(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .cen(cen), .bus(bus0));
   tv80_bus_seq #(.AW(16), .DW(8), .T2WRITE(0), .MEM_WAIT(2), .IO_WAIT(0), .REFRESH(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .cen(cen), .bus(bus1));

   assign bus0.req_valid = req_valid && !sel;
   assign bus1.req_valid = req_valid && sel;
   assign bus0.req_type  = req_type;   assign bus1.req_type  = req_type;
   assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;
   assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;
   assign bus0.rfsh_page = rfsh_page;  assign bus1.rfsh_page = rfsh_page;
   assign bus0.wait_n    = wait_n;     assign bus1.wait_n    = wait_n;
   assign bus0.di        = di;         assign bus1.di        = di;

   logic [5:0]  o_strb;
   logic [15:0] o_a;
   logic [7:0]  o_dout, o_rdata;
   logic        o_ready, o_rsp;

   always_comb begin
      if (!sel) begin
         o_strb  = {bus0.m1_n, bus0.mreq_n, bus0.iorq_n, bus0.rd_n, bus0.wr_n, bus0.rfsh_n};
         o_a     = bus0.A;
         o_dout  = bus0.dout;
         o_rdata = bus0.rsp_rdata;
         o_ready = bus0.req_ready;
         o_rsp   = bus0.rsp_valid;
      end else begin
         o_strb  = {bus1.m1_n, bus1.mreq_n, bus1.iorq_n, bus1.rd_n, bus1.wr_n, bus1.rfsh_n};
         o_a     = bus1.A;
         o_dout  = bus1.dout;
         o_rdata = bus1.rsp_rdata;
         o_ready = bus1.req_ready;
         o_rsp   = bus1.rsp_valid;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", tag, txn_no, obs, exp);
      end
   endtask

   task automatic clk_edge(input logic c);
      cen = c;
      @(posedge clk);
      #1;
   endtask

   function automatic int auto_waits(input logic [2:0] t);
      if (t == REQ_IO_RD || t == REQ_IO_WR) return p_io_wait;
      if (t == REQ_INT_ACK) return p_io_wait + 1;
      return p_mem_wait;
   endfunction

   // Strobes {m1,mreq,iorq,rd,wr,rfsh} after cen edge e of a cycle with n TW states:
   // e=1 T1, e=2..2+n T2/TW, e=3+n T3, e=4+n T4 (refresh fetch only).
   function automatic logic [5:0] exp_strb(input logic [2:0] t, input int e, input int n, input bit rf);
      logic m1, mreq, iorq, rd, wr, rfsh;
      {m1, mreq, iorq, rd, wr, rfsh} = 6'h3F;
      if (e == 1) begin
         m1 = !(t == REQ_FETCH || t == REQ_INT_ACK);
      end else if (rf && e == 3 + n) begin
         rfsh = 1'b0;
      end else if (rf && e == 4 + n) begin
         mreq = 1'b0;
         rfsh = 1'b0;
      end else begin
         case (t)
            REQ_FETCH:   begin m1 = 1'b0; mreq = 1'b0; rd = 1'b0; end
            REQ_MEM_RD:  begin mreq = 1'b0; rd = 1'b0; end
            REQ_MEM_WR:  begin mreq = 1'b0; wr = (e == 3 + n || p_t2write) ? 1'b0 : 1'b1; end
            REQ_IO_RD:   begin iorq = 1'b0; rd = 1'b0; end
            REQ_IO_WR:   begin iorq = 1'b0; wr = 1'b0; end
            REQ_INT_ACK: begin m1 = 1'b0; iorq = 1'b0; end
            default: ;
         endcase
      end
      return {m1, mreq, iorq, rd, wr, rfsh};
   endfunction

   task automatic maybe_gap();
      if ($urandom_range(0, 3) == 0) begin
         clk_edge(1'b0);
         check_val("gap_strobes", 32'(o_strb), 32'(exp_now));
         check_val("gap_rsp_valid", 32'(o_rsp), 32'd0);
      end
   endtask

   task automatic run_txn(input logic [2:0] t, input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] dv, input logic [7:0] page, input int k, input int abort_at);
      bit rsv, rf, rd_t, wr_t;
      int n, last;
      logic [15:0] ea;
      txn_no++;
      rsv  = (t > REQ_INT_ACK);
      rf   = (t == REQ_FETCH) && p_refresh;
      rd_t = (t == REQ_FETCH || t == REQ_MEM_RD || t == REQ_IO_RD || t == REQ_INT_ACK);
      wr_t = (t == REQ_MEM_WR || t == REQ_IO_WR);
      n    = (k > auto_waits(t)) ? k : auto_waits(t);
      last = rsv ? 2 : (4 + n + (rf ? 1 : 0));
      $display("txn %0d dut%0d type=%0d addr=%04h wdata=%02h di=%02h ext_wait=%0d tw=%0d",
               txn_no, sel, t, addr, wd, dv, k, rsv ? 0 : n);
      check_val("ready_before_accept", 32'(o_ready), 32'd1);
      req_valid = 1'b1;
      req_type  = t;
      req_addr  = addr;
      req_wdata = wd;
      rfsh_page = page;
      for (int e = 1; e < last; e++) begin
         wait_n = (e >= 3 && e <= k + 2) ? 1'b0 : 1'b1;
         di     = (e == 3 + n) ? dv : ~dv;
         maybe_gap();
         clk_edge(1'b1);
         if (e == 1) begin
            req_valid = 1'b0;
            check_val("rsp_valid_at_accept", 32'(o_rsp), 32'(pending || rsv));
            pending = 1'b0;
         end else begin
            check_val("rsp_valid_mid_cycle", 32'(o_rsp), 32'd0);
         end
         if (!rsv && rd_t && e == 3 + n) exp_rdata = dv;
         check_val("rsp_rdata", 32'(o_rdata), 32'(exp_rdata));
         if (rsv) begin
            exp_now = 6'h3F;
            check_val("reserved_strobes", 32'(o_strb), 32'(exp_now));
            check_val("reserved_ready", 32'(o_ready), 32'd1);
         end else begin
            exp_now = exp_strb(t, e, n, rf);
            ea = (rf && e >= 3 + n) ? {page, rcnt_m} : addr;
            check_val("strobes", 32'(o_strb), 32'(exp_now));
            check_val("address", 32'(o_a), 32'(ea));
            if (wr_t) check_val("dout", 32'(o_dout), 32'(wd));
            check_val("req_ready", 32'(o_ready), 32'(e == last - 1));
         end
         if (e == abort_at) begin
            reset_n   = 1'b0;
            clk_edge(1'b0);
            reset_n   = 1'b1;
            check_val("reset_strobes", 32'(o_strb), 32'h3F);
            check_val("reset_rsp_valid", 32'(o_rsp), 32'd0);
            check_val("reset_ready", 32'(o_ready), 32'd1);
            check_val("reset_address", 32'(o_a), 32'd0);
            check_val("reset_dout", 32'(o_dout), 32'd0);
            check_val("reset_rdata", 32'(o_rdata), 32'd0);
            exp_rdata = 8'h00;
            rcnt_m    = 8'h00;
            pending   = 1'b0;
            exp_now   = 6'h3F;
            return;
         end
      end
      pending = !rsv;
      if (rf) rcnt_m[6:0] = rcnt_m[6:0] + 7'd1;
   endtask

   task automatic idle_edge();
      req_valid = 1'b0;
      wait_n    = 1'b1;
      maybe_gap();
      clk_edge(1'b1);
      check_val("rsp_valid_at_end", 32'(o_rsp), 32'(pending));
      check_val("rsp_rdata_at_end", 32'(o_rdata), 32'(exp_rdata));
      check_val("idle_strobes", 32'(o_strb), 32'h3F);
      check_val("idle_ready", 32'(o_ready), 32'd1);
      pending = 1'b0;
      exp_now = 6'h3F;
   endtask

   task automatic run_rand(input int count);
      for (int i = 0; i < count; i++) begin
         int r;
         int k;
         logic [2:0] t;
         r = $urandom_range(0, 9);
         if (r <= 3)      t = REQ_FETCH;
         else if (r == 9) t = 3'($urandom_range(6, 7));
         else             t = 3'(r - 3);
         k = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         run_txn(t, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), k, 0);
         if ($urandom_range(0, 1) == 0) idle_edge();
      end
   endtask

   initial begin
      sel = 1'b0;
      p_t2write = 1'b1; p_refresh = 1'b1; p_mem_wait = 0; p_io_wait = 1;
      reset_n = 1'b0; cen = 1'b0; req_valid = 1'b0; req_type = 3'd0;
      req_addr = '0; req_wdata = '0; rfsh_page = '0; di = '0; wait_n = 1'b1;
      pending = 1'b0; exp_rdata = 8'h00; rcnt_m = 8'h00; exp_now = 6'h3F;
      repeat (3) clk_edge(1'b1);
      reset_n = 1'b1;
      check_val("por_strobes", 32'(o_strb), 32'h3F);
      check_val("por_address", 32'(o_a), 32'd0);
      check_val("por_dout", 32'(o_dout), 32'd0);
      check_val("por_rsp_valid", 32'(o_rsp), 32'd0);
      check_val("por_rdata", 32'(o_rdata), 32'd0);
      check_val("por_ready", 32'(o_ready), 32'd1);

      run_txn(REQ_FETCH,  16'h0000, 8'h00, 8'h3E, 8'h12, 0, 0); idle_edge();
      run_txn(REQ_IO_RD,  16'h00FE, 8'h00, 8'hA5, 8'h12, 0, 0); idle_edge();
      run_txn(REQ_MEM_WR, 16'h8000, 8'h55, 8'h00, 8'h12, 0, 0); idle_edge();
      run_txn(REQ_MEM_RD, 16'h1234, 8'h00, 8'h77, 8'h12, 3, 0); idle_edge();
      for (int i = 0; i < 3; i++) run_txn(REQ_MEM_RD, 16'(16'h4000 + i), 8'h00, 8'(8'h10 + i), 8'h12, 0, 0);
      idle_edge();
      run_txn(REQ_INT_ACK, 16'h0038, 8'h00, 8'hFF, 8'h12, 0, 0);
      run_txn(3'd6, 16'h0000, 8'h00, 8'h00, 8'h12, 0, 0);
      run_txn(REQ_IO_WR, 16'h0042, 8'h99, 8'h00, 8'h12, 5, 4);
      run_txn(REQ_IO_WR, 16'h0043, 8'h9A, 8'h00, 8'h12, 0, 0); idle_edge();
      run_rand(400);
      idle_edge();

      sel = 1'b1;
      p_t2write = 1'b0; p_refresh = 1'b0; p_mem_wait = 2; p_io_wait = 0;
      exp_rdata = 8'h00; pending = 1'b0; exp_now = 6'h3F;
      run_txn(REQ_MEM_WR, 16'h8000, 8'h55, 8'h00, 8'h00, 0, 0); idle_edge();
      run_txn(REQ_FETCH,  16'h0100, 8'h00, 8'hC3, 8'h00, 1, 0); idle_edge();
      run_rand(150);
      idle_edge();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
